// File: rtl/instr_encoder_if.sv
// Purpose : bundles the field-input stream and the instruction-memory write port of instr_encoder.
// Latency : n/a (wires only).
// Backpressure: in_valid/in_ready on the field stream, wr_en/wr_ready on the write port.
// Ports   : in_valid, in_ready, in_last, in_opcode, in_funct3, in_alt, in_rd, in_rs1, in_rs2, in_imm,
//           wr_en, wr_ready, wr_addr, wr_data.
// Modports: slave = the encoder (consumes fields, drives writes); master = the loader/bench side.
interface instr_encoder_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32
);
  logic                  in_valid;
  logic                  in_ready;
  logic                  in_last;
  logic [6:0]            in_opcode;
  logic [2:0]            in_funct3;
  logic                  in_alt;
  logic [4:0]            in_rd;
  logic [4:0]            in_rs1;
  logic [4:0]            in_rs2;
  logic [31:0]           in_imm;
  logic                  wr_en;
  logic                  wr_ready;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;

  modport slave (
    input  in_valid, in_last, in_opcode, in_funct3, in_alt, in_rd, in_rs1, in_rs2, in_imm,
    input  wr_ready,
    output in_ready, wr_en, wr_addr, wr_data
  );

  modport master (
    output in_valid, in_last, in_opcode, in_funct3, in_alt, in_rd, in_rs1, in_rs2, in_imm,
    output wr_ready,
    input  in_ready, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/instr_encoder.sv
// Purpose : packs RV32I fields into 32-bit words and streams them to instruction memory from base_addr.
// Latency : 1 cycle from accepted field bundle to wr_en/wr_data/wr_addr.
// Backpressure: one-entry output register; in_ready drops while it is full and wr_ready is low.
// Ports   : clk, rst_n (async active-low), start/base_addr (session start), bus (instr_encoder_if.slave:
//           field stream + write port), busy, done (1-cycle pulse), err_illegal, err_range (sticky).
// Option  : define IMM_RANGE_CHECK_EN to flag out-of-range/misaligned immediates on err_range;
//           without it err_range is tied low and excess immediate bits are silently dropped.
module instr_encoder #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  instr_encoder_if.slave        bus,
  output logic                  busy,
  output logic                  done,
  output logic                  err_illegal,
  output logic                  err_range
);
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_DRAIN, ST_DONE} state_t;

  state_t                state, state_nx;
  logic [ADDR_WIDTH-1:0] addr_q;      // address the next accepted word will be written to
  logic [DATA_WIDTH-1:0] enc;
  logic                  enc_illegal;
  logic                  is_shift;
  logic [6:0]            funct7;
  logic                  accept, wr_hs, start_ok;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [4:0]  rd, rs1, rs2;
  logic [31:0] imm;

  assign opcode = bus.in_opcode;
  assign funct3 = bus.in_funct3;
  assign rd     = bus.in_rd;
  assign rs1    = bus.in_rs1;
  assign rs2    = bus.in_rs2;
  assign imm    = bus.in_imm;
  assign funct7 = bus.in_alt ? 7'b0100000 : 7'b0000000;
  assign is_shift = (opcode == OP_IMM) && ((funct3 == 3'b001) || (funct3 == 3'b101));

  // Skid of one: a new bundle may enter in the same cycle the held word drains.
  assign bus.in_ready = (state == ST_LOAD) && (!bus.wr_en || bus.wr_ready);
  assign accept       = bus.in_valid && bus.in_ready;
  assign wr_hs        = bus.wr_en && bus.wr_ready;
  assign start_ok     = start && (state == ST_IDLE);
  assign busy         = (state != ST_IDLE);
  assign done         = (state == ST_DONE);

  always_comb begin
    enc         = 32'h0000_0013;
    enc_illegal = 1'b0;
    case (opcode)
      OP_R:    enc = {funct7, rs2, rs1, funct3, rd, opcode};
      OP_IMM:  enc = is_shift ? {funct7, imm[4:0], rs1, funct3, rd, opcode}
                              : {imm[11:0], rs1, funct3, rd, opcode};
      OP_LOAD, OP_JALR:
               enc = {imm[11:0], rs1, funct3, rd, opcode};
      OP_STORE:  enc = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
      OP_BRANCH: enc = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
      OP_JAL:    enc = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
      OP_LUI, OP_AUIPC:
               enc = {imm[31:12], rd, opcode};
      // Only ecall/ebreak are produced; every other SYSTEM field is forced to zero.
      OP_SYSTEM: enc = imm[0] ? 32'h0010_0073 : 32'h0000_0073;
      default: enc_illegal = 1'b1;
    endcase
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (start)                  state_nx = ST_LOAD;
      ST_LOAD:  if (accept && bus.in_last)  state_nx = ST_DRAIN;
      ST_DRAIN: if (wr_hs)                  state_nx = ST_DONE;
      ST_DONE:                              state_nx = ST_IDLE;
      default:                              state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      addr_q      <= '0;
      bus.wr_en   <= 1'b0;
      bus.wr_addr <= '0;
      bus.wr_data <= '0;
      err_illegal <= 1'b0;
    end else begin
      state <= state_nx;
      if (start_ok) begin
        addr_q      <= base_addr;
        err_illegal <= 1'b0;
      end
      if (accept) begin
        bus.wr_en   <= 1'b1;
        bus.wr_data <= enc;
        bus.wr_addr <= addr_q;
        addr_q      <= addr_q + ADDR_WIDTH'(4);
        if (enc_illegal) err_illegal <= 1'b1;
      end else if (wr_hs) begin
        bus.wr_en <= 1'b0;
      end
    end
  end

`ifdef IMM_RANGE_CHECK_EN
  logic signed [31:0] simm;
  logic               range_fault;

  assign simm = $signed(imm);

  always_comb begin
    range_fault = 1'b0;
    case (opcode)
      OP_IMM:  range_fault = is_shift ? (imm > 32'd31)
                                      : ((simm < -32'sd2048) || (simm > 32'sd2047));
      OP_LOAD, OP_JALR, OP_STORE:
               range_fault = (simm < -32'sd2048) || (simm > 32'sd2047);
      OP_BRANCH: range_fault = (simm < -32'sd4096) || (simm > 32'sd4094) || imm[0];
      OP_JAL:    range_fault = (simm < -32'sd1048576) || (simm > 32'sd1048574) || imm[0];
      OP_LUI, OP_AUIPC:
               range_fault = (imm[11:0] != 12'h000);
      default: range_fault = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                     err_range <= 1'b0;
    else if (start_ok)              err_range <= 1'b0;
    else if (accept && range_fault) err_range <= 1'b1;
  end
`else
  assign err_range = 1'b0;
`endif
endmodule
